// File: rtl/gpio_pkg.sv
// Purpose : shared address map and types for the memory-mapped GPIO block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package gpio_pkg;

  // Bus data width seen by the core; pin count is a parameter of gpio_ctrl.
  localparam int GPIO_BUS_W = 32;

  // Word offsets (addr[4:2] of the byte address).
  typedef logic [2:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_DATA_OUT = 3'd0;  // RW
  localparam gpio_addr_t GPIO_DIR      = 3'd1;  // RW, 1 = drive pin
  localparam gpio_addr_t GPIO_DATA_IN  = 3'd2;  // RO, synchronised pins
  localparam gpio_addr_t GPIO_OUT_SET  = 3'd3;  // W1S on DATA_OUT
  localparam gpio_addr_t GPIO_OUT_CLR  = 3'd4;  // W1C on DATA_OUT
  localparam gpio_addr_t GPIO_IRQ_EN   = 3'd5;  // RW
  localparam gpio_addr_t GPIO_IRQ_STAT = 3'd6;  // R / W1C, sticky
  localparam gpio_addr_t GPIO_RSVD     = 3'd7;  // reads 0, writes dropped

endpackage

// File: rtl/gpio_if.sv
// Purpose : data-memory bus slice between the address decoder/core and the GPIO block.
// Latency : n/a (wires only); rd and gstb are registered inside the slave.
// Backpressure: none; the slave accepts an access every cycle.
// Signals : enable (block select), memwrite (1 = write), addr (word offset),
//           wd (write data), rd (registered read data), gstb (access strobe).
interface gpio_if;
  import gpio_pkg::*;

  logic                  enable;
  logic                  memwrite;
  gpio_addr_t            addr;
  logic [GPIO_BUS_W-1:0] wd;
  logic [GPIO_BUS_W-1:0] rd;
  logic                  gstb;

  // Core / decoder side.
  modport master (
    output enable, memwrite, addr, wd,
    input  rd, gstb
  );

  // Peripheral side.
  modport slave (
    input  enable, memwrite, addr, wd,
    output rd, gstb
  );

endinterface

// File: rtl/gpio_sync.sv
// Purpose : multi-flop synchroniser for asynchronous pin inputs plus rising-edge detect.
// Latency : sync is SYNC_STAGES cycles behind gpi; rise is one cycle wide, same cycle as sync.
// Backpressure: none; free-running every cycle.
// Ports   : clk, reset (async, active-high), gpi[WIDTH] in;
//           sync[WIDTH] (synchronised pins), rise[WIDTH] (sync & ~prev) out.
module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpi,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    stage_d[0] = gpi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    // prev trails the synchroniser output by one cycle, updated unconditionally.
    prev_d = stage_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Purpose : WIDTH-pin GPIO peripheral: output/direction regs, atomic set/clear, synced inputs, edge IRQs.
// Latency : writes visible on pins next cycle; rd valid the cycle after a read; gstb one cycle after access.
// Backpressure: none; one access per cycle, back-to-back accesses allowed.
// Ports   : clk, reset (async, active-high); bus (gpio_if.slave: enable, memwrite, addr, wd, rd, gstb);
//           gpi[WIDTH] async pins in; gpo[WIDTH] pin values, gpo_oe[WIDTH] pin drive enables,
//           irq level interrupt (OR of sticky status).
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_if.slave            bus,
  input  logic [WIDTH-1:0] gpi,
  output logic [WIDTH-1:0] gpo,
  output logic [WIDTH-1:0] gpo_oe,
  output logic             irq
);

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] pin_rise;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .gpi   (gpi),
    .sync  (pin_sync),
    .rise  (pin_rise)
  );

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]      data_out_q, data_out_d;
  logic [WIDTH-1:0]      dir_q,      dir_d;
  logic [WIDTH-1:0]      irq_en_q,   irq_en_d;
  logic [WIDTH-1:0]      irq_stat_q, irq_stat_d;
  logic [GPIO_BUS_W-1:0] rd_q,       rd_d;
  logic                  gstb_q,     gstb_d;

  logic                  wr_en;
  logic                  rd_en;
  logic [WIDTH-1:0]      wd_pins;
  logic [WIDTH-1:0]      stat_clr;
  logic [WIDTH-1:0]      rd_sel;

  assign wr_en   = bus.enable &  bus.memwrite;
  assign rd_en   = bus.enable & ~bus.memwrite;
  assign wd_pins = bus.wd[WIDTH-1:0];

  // Write data above the pin count carries no meaning for this block.
  if (WIDTH < GPIO_BUS_W) begin : g_wd_hi
    logic unused_wd_hi;
    assign unused_wd_hi = ^bus.wd[GPIO_BUS_W-1:WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Read mux (side-effect free)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_sel = '0;
    case (bus.addr)
      GPIO_DATA_OUT,
      GPIO_OUT_SET,
      GPIO_OUT_CLR:  rd_sel = data_out_q;
      GPIO_DIR:      rd_sel = dir_q;
      GPIO_DATA_IN:  rd_sel = pin_sync;
      GPIO_IRQ_EN:   rd_sel = irq_en_q;
      GPIO_IRQ_STAT: rd_sel = irq_stat_q;
      default:       rd_sel = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write decode and next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    stat_clr   = '0;
    rd_d       = rd_q;
    gstb_d     = bus.enable;

    if (wr_en) begin
      case (bus.addr)
        GPIO_DATA_OUT: data_out_d = wd_pins;
        GPIO_DIR:      dir_d      = wd_pins;
        GPIO_OUT_SET:  data_out_d = data_out_q |  wd_pins;
        GPIO_OUT_CLR:  data_out_d = data_out_q & ~wd_pins;
        GPIO_IRQ_EN:   irq_en_d   = wd_pins;
        GPIO_IRQ_STAT: stat_clr   = wd_pins;
        default:       ;  // DATA_IN and reserved ignore writes
      endcase
    end

    // Set term is ORed after the clear so a coincident edge keeps the bit high.
    // Enable is the pre-write value: an edge on a disabled pin is simply lost.
    irq_stat_d = (irq_stat_q & ~stat_clr) | (pin_rise & irq_en_q);

    if (rd_en) begin
      rd_d              = '0;
      rd_d[WIDTH-1:0]   = rd_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      rd_q       <= '0;
      gstb_q     <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      rd_q       <= rd_d;
      gstb_q     <= gstb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gpo      = data_out_q;
  assign gpo_oe   = dir_q;
  assign irq      = |irq_stat_q;
  assign bus.rd   = rd_q;
  assign bus.gstb = gstb_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Purpose : self-checking bench for gpio_ctrl (WIDTH=8 main instance, WIDTH=4 width check).
// Latency : n/a.
// Backpressure: n/a.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gpio_if bus8();
  gpio_if bus4();

  logic [W-1:0] gpi;
  logic [W-1:0] gpo;
  logic [W-1:0] gpo_oe;
  logic         irq;
  logic [3:0]   gpi4;
  logic [3:0]   gpo4;
  logic [3:0]   gpo_oe4;
  logic         irq4;

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus8),
    .gpi    (gpi),
    .gpo    (gpo),
    .gpo_oe (gpo_oe),
    .irq    (irq)
  );

  gpio_ctrl #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus4),
    .gpi    (gpi4),
    .gpo    (gpo4),
    .gpo_oe (gpo_oe4),
    .irq    (irq4)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: registers as plain variables, synchroniser as a delay line
  // of pin samples (hist[0] = pins captured at the latest edge).
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_out, m_dir, m_en, m_stat;
  logic [31:0]  m_rd;
  logic         m_gstb;
  logic [W-1:0] m_hist [0:SS];

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_rd = '0; m_gstb = 1'b0;
    for (int k = 0; k <= SS; k++) m_hist[k] = '0;
  endtask

  function automatic logic [31:0] model_read(input gpio_addr_t a, input logic [W-1:0] pins);
    logic [W-1:0] v;
    case (a)
      3'd0, 3'd3, 3'd4: v = m_out;
      3'd1:             v = m_dir;
      3'd2:             v = pins;
      3'd5:             v = m_en;
      3'd6:             v = m_stat;
      default:          v = '0;
    endcase
    return {24'h0, v};
  endfunction

  task automatic model_edge(input logic en, input logic we, input gpio_addr_t a,
                            input logic [31:0] w, input logic [W-1:0] g);
    logic [W-1:0] pins, edges, en_before, clr, wv;
    pins      = m_hist[SS-1];          // value gpi had SS edges ago
    edges     = pins & ~m_hist[SS];    // pin was 0 one cycle earlier, 1 now
    en_before = m_en;
    clr       = '0;
    wv        = w[W-1:0];
    if (en && !we) m_rd = model_read(a, pins);
    if (en && we) begin
      case (a)
        3'd0: m_out = wv;
        3'd1: m_dir = wv;
        3'd3: m_out = m_out | wv;
        3'd4: m_out = m_out & ~wv;
        3'd5: m_en  = wv;
        3'd6: clr   = wv;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | (edges & en_before);
    m_gstb = en;
    for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = g;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gpo"},    {24'h0, gpo},    {24'h0, m_out});
    check({tag, ".gpo_oe"}, {24'h0, gpo_oe}, {24'h0, m_dir});
    check({tag, ".irq"},    {31'h0, irq},    {31'h0, (m_stat != '0)});
    check({tag, ".gstb"},   {31'h0, bus8.gstb}, {31'h0, m_gstb});
    check({tag, ".rd"},     bus8.rd,         m_rd);
  endtask

  // One bus cycle: drive at negedge, model the edge, sample #1 after it.
  task automatic cyc(input logic en, input logic we, input gpio_addr_t a,
                     input logic [31:0] w, input logic [W-1:0] g);
    bus8.enable   = en;
    bus8.memwrite = we;
    bus8.addr     = a;
    bus8.wd       = w;
    gpi           = g;
    @(posedge clk);
    model_edge(en, we, a, w, g);
    #1;
    check_all("cyc");
    @(negedge clk);
  endtask

  task automatic wr(input gpio_addr_t a, input logic [31:0] w);
    cyc(1'b1, 1'b1, a, w, gpi);
  endtask

  task automatic rdr(input gpio_addr_t a);
    cyc(1'b1, 1'b0, a, 32'h0, gpi);
  endtask

  task automatic idle(input int n, input logic [W-1:0] g);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'h0, g);
  endtask

  initial begin
    bus8.enable = 1'b0; bus8.memwrite = 1'b0; bus8.addr = '0; bus8.wd = '0;
    bus4.enable = 1'b0; bus4.memwrite = 1'b0; bus4.addr = '0; bus4.wd = '0;
    gpi = '0; gpi4 = '0;
    model_reset();

    // Reset state, sampled before any clock edge.
    #2;
    check_all("reset0");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rdr(gpio_addr_t'(a));
      check($sformatf("rst_reg%0d", a), bus8.rd, 32'h0);
    end

    // Output path.
    wr(GPIO_DIR, 32'hFF);
    check("dir_ff", {24'h0, gpo_oe}, 32'hFF);
    wr(GPIO_DATA_OUT, 32'h0F);
    check("gpo_0f", {24'h0, gpo}, 32'h0F);
    wr(GPIO_OUT_SET, 32'h30);
    check("gpo_set", {24'h0, gpo}, 32'h3F);
    wr(GPIO_OUT_CLR, 32'h05);
    check("gpo_clr", {24'h0, gpo}, 32'h3A);
    rdr(GPIO_DATA_OUT);
    check("rd_out", bus8.rd, 32'h3A);
    rdr(GPIO_OUT_SET);
    check("rd_set_alias", bus8.rd, 32'h3A);

    // Input synchroniser: two reads see the old value, the third the new one.
    idle(3, 8'h00);
    cyc(1'b1, 1'b0, GPIO_DATA_IN, 32'h0, 8'hA5);
    check("din_lag1", bus8.rd, 32'h00);
    cyc(1'b1, 1'b0, GPIO_DATA_IN, 32'h0, 8'hA5);
    check("din_lag2", bus8.rd, 32'h00);
    cyc(1'b1, 1'b0, GPIO_DATA_IN, 32'h0, 8'hA5);
    check("din_new", bus8.rd, 32'hA5);
    rdr(GPIO_IRQ_STAT);
    check("stat_masked", bus8.rd, 32'h0);

    // Interrupt: only the enabled pin latches.
    idle(4, 8'h00);
    wr(GPIO_IRQ_EN, 32'h01);
    idle(1, 8'h03);
    idle(4, 8'h00);
    rdr(GPIO_IRQ_STAT);
    check("stat_bit0", bus8.rd, 32'h01);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(GPIO_IRQ_STAT, 32'h01);
    check("irq_clr", {31'h0, irq}, 32'h0);

    // Set beats clear: W1C lands on the same edge as a fresh rise on bit 0.
    idle(1, 8'h01);
    idle(3, 8'h00);
    check("irq_pre", {31'h0, irq}, 32'h1);
    idle(2, 8'h01);
    wr(GPIO_IRQ_STAT, 32'h01);
    check("irq_setwins", {31'h0, irq}, 32'h1);
    rdr(GPIO_IRQ_STAT);
    check("stat_setwins", bus8.rd, 32'h01);

    // Strobe: read then write back-to-back, then idle.
    rdr(GPIO_DIR);
    check("gstb_rd", {31'h0, bus8.gstb}, 32'h1);
    wr(GPIO_IRQ_EN, 32'h00);
    check("gstb_wr", {31'h0, bus8.gstb}, 32'h1);
    idle(1, gpi);
    check("gstb_idle", {31'h0, bus8.gstb}, 32'h0);
    wr(GPIO_IRQ_EN, 32'h01);
    rdr(GPIO_DATA_OUT);

    // Mid-cycle reset with pin 0 held high across release.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("mrst_gpo",    {24'h0, gpo},    32'h0);
    check("mrst_gpo_oe", {24'h0, gpo_oe}, 32'h0);
    check("mrst_rd",     bus8.rd,         32'h0);
    check("mrst_irq",    {31'h0, irq},    32'h0);
    check("mrst_gstb",   {31'h0, bus8.gstb}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rdr(gpio_addr_t'(a));
      if (a != 2) check($sformatf("mrst_reg%0d", a), bus8.rd, 32'h0);
    end
    idle(3, gpi);
    rdr(GPIO_IRQ_STAT);
    check("mrst_edge_masked", bus8.rd, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic          en, we;
      gpio_addr_t    a;
      logic [31:0]   w;
      logic [W-1:0]  g;
      en = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      a  = gpio_addr_t'($urandom_range(0, 7));
      w  = $urandom;
      g  = ($urandom_range(0, 2) == 0) ? W'($urandom) : gpi;
      cyc(en, we, a, w, g);
    end
    idle(1, gpi);

    // Narrow instance: upper write bits dropped, upper read bits zero.
    bus4.enable = 1'b1; bus4.memwrite = 1'b1; bus4.addr = GPIO_DATA_OUT; bus4.wd = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("w4_gpo", {28'h0, gpo4}, 32'hF);
    @(negedge clk);
    bus4.addr = GPIO_DIR;
    @(posedge clk); #1;
    check("w4_oe", {28'h0, gpo_oe4}, 32'hF);
    @(negedge clk);
    bus4.memwrite = 1'b0; bus4.addr = GPIO_DATA_OUT;
    @(posedge clk); #1;
    check("w4_rd", bus4.rd, 32'h0000_000F);
    check("w4_gstb", {31'h0, bus4.gstb}, 32'h1);
    @(negedge clk);
    bus4.addr = GPIO_RSVD;
    @(posedge clk); #1;
    check("w4_rsvd", bus4.rd, 32'h0);
    check("w4_irq", {31'h0, irq4}, 32'h0);
    @(negedge clk);
    bus4.enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
